fetch_unit: RTL and testbench
=============================

# fetch_unit

Fetch stage of the pipelined ARM core: owns PCF, issues instruction-memory requests over a grant/response handshake, buffers returned words in a 2-entry queue and drives the Fetch/Decode pipeline register. It is the consumer of the hazard unit's StallF/StallD/FlushD controls and of the PC redirects. It absorbs variable instruction-memory latency and presents ValidD=0 bubbles to decode when no instruction is ready.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction width
- RESET_PC, 32'h0, PCF value after reset
- clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- StallF  in  1  hold PCF, issue no new request
- StallD  in  1  hold Fetch/Decode register
- FlushD  in  1  invalidate Fetch/Decode register and queue
- BranchTakenE  in  1  redirect from Execute
- BranchTargetE  in  ADDR_W  redirect target from Execute
- PCSrcW  in  1  redirect from Writeback (PC written by instruction)
- ResultW  in  ADDR_W  redirect target from Writeback
- ImemReq  out  1  request valid
- ImemAddr  out  ADDR_W  request address (= PCF)
- ImemGnt  in  1  request accepted this cycle
- ImemRvalid  in  1  response data valid
- ImemRdata  in  DATA_W  response instruction
- InstrD  out  DATA_W  instruction in Decode
- PCPlus8D  out  ADDR_W  fetch address of InstrD + 8
- ValidD  out  1  InstrD is a real instruction

## Operation
- FSM states: REQ (ImemReq may be asserted, no request outstanding), RESP (one granted request outstanding), DROP (outstanding response belongs to a squashed path).
- At most one outstanding request. ImemReq=1 only in REQ, when StallF=0, no redirect this cycle, and queue count < 2.
- REQ with ImemGnt: PCF <= PCF+4 (mod 2^ADDR_W), go RESP. ImemReq/ImemAddr may change while not yet granted.
- RESP with ImemRvalid: word + its fetch address written to queue, or bypassed straight into Decode register if queue empty and StallD=0 and FlushD=0; go REQ.
- DROP with ImemRvalid: data discarded; go REQ.
- Redirect: PCSrcW has priority over BranchTakenE (older instruction wins). PCF <= target; queue cleared; RESP -> DROP; REQ stays REQ; DROP stays DROP.
- Redirect and ImemGnt same cycle cannot happen (ImemReq forced 0 during redirect).
- Decode register: StallD=1 holds InstrD/PCPlus8D/ValidD; FlushD=1 (priority over StallD) clears ValidD and queue; else loads queue head (pop) or bypass data with ValidD=1, or ValidD=0 if nothing available.
- FlushD during RESP does not change FSM state; only a redirect squashes the outstanding response.
- StallF does not block acceptance of an outstanding response.
- PCPlus8D = entry address + 8, mod 2^ADDR_W.

## Timing
- Reset values: PCF=RESET_PC, state REQ, queue empty, ValidD=0, InstrD=0, PCPlus8D=0, ImemReq=0 while Reset=1.
- Reset mid-transaction: outstanding response is not tracked; memory must be reset together.
- ImemRvalid earliest one cycle after ImemGnt.
- Best-case: grant cycle N, Rvalid cycle N+1, ValidD=1 in N+2 (bypass). Throughput one instruction per 2 cycles minimum.
- Redirect in cycle N: ImemReq to target earliest in N+1 (N+1 later if DROP pending).
- Queue full (2) + StallD: no request issued; no overflow possible.

## Structure
- fetch_pkg: fetch_state_t enum {REQ, RESP, DROP}; fetch_entry_t struct {instr, addr}; PC_INC=4, PC_D_OFS=8.
- Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with push, pop, clear, count, head.

## Test plan
- Reset RESET_PC=0, memory grants immediately, Rvalid next cycle -> ImemAddr 0,4,8 on alternate cycles; PCPlus8D 8,12,16; ValidD toggles 1 every other cycle.
- StallD=1 for 6 cycles with data returning -> queue reaches 2, ImemReq stays 0, InstrD held; release -> two instructions in consecutive cycles.
- BranchTakenE=1, target 0x100, while in RESP -> response discarded, next ImemAddr 0x100, no stale instruction reaches Decode.
- PCSrcW (0x200) and BranchTakenE (0x300) same cycle -> next ImemAddr 0x200.
- FlushD=1 with StallD=1 and queue full -> ValidD=0 next cycle, queue empty.
- PCF=0xFFFFFFFC granted -> PCF wraps to 0, PCPlus8D=0x00000004.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t : request FSM states (StReq, StResp, StDrop)
//   fetch_entry_t : instruction word plus the address it was fetched from
//   PC_INC        : sequential PC step
//   PC_D_OFS      : offset from fetch address to the PC+8 value seen in Decode
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] PC_INC   = FETCH_ADDR_W'(4);
    localparam logic [FETCH_ADDR_W-1:0] PC_D_OFS = FETCH_ADDR_W'(8);

    typedef enum logic [1:0] {
        StReq,
        StResp,
        StDrop
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bundle.
//   req    : request valid (fetch -> memory)
//   addr   : request address (fetch -> memory)
//   gnt    : request accepted this cycle (memory -> fetch)
//   rvalid : response data valid (memory -> fetch)
//   rdata  : response instruction word (memory -> fetch)
// master modport is the fetch side, slave modport is the memory side.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch_entry_t.
//   clk, rst : clock, asynchronous active-high reset
//   push_i   : write entry_i at the tail
//   entry_i  : entry to write
//   pop_i    : drop the head entry (ignored when empty)
//   clear_i  : empty the queue; a push in the same cycle lands in the emptied queue
//   count_o  : number of valid entries (0..2)
//   head_o   : oldest entry (don't-care when count_o == 0)
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0) && !clear_i;
        // A full queue only takes a push if a pop frees a slot in the same cycle.
        do_push  = push_i && (clear_i || (count_q != 2'd2) || do_pop);
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_ptr   = rd_ptr_q ^ count_q[0];

        if (clear_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr   = 1'b0;
            count_d  = do_push ? 2'd1 : 2'd0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr] <= entry_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage of the pipelined ARM core.
// Owns PCF, issues one instruction-memory request at a time over a grant/response
// handshake, buffers returned words in a 2-entry queue and drives the Fetch/Decode
// register. ValidD=0 marks a bubble when no instruction is ready.
//   clk, rst              : clock, asynchronous active-high reset
//   stall_f_i             : hold PCF, issue no new request
//   stall_d_i             : hold the Fetch/Decode register
//   flush_d_i             : invalidate the Fetch/Decode register and the queue
//   branch_taken_e_i/
//   branch_target_e_i     : redirect from Execute
//   pc_src_w_i/result_w_i : redirect from Writeback (wins over Execute)
//   imem_io               : instruction-memory request/response (master side)
//   instr_d_o             : instruction in Decode
//   pc_plus8_d_o          : fetch address of instr_d_o + 8
//   valid_d_o             : instr_d_o is a real instruction
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_f_i,
    input  logic               stall_d_i,
    input  logic               flush_d_i,
    input  logic               branch_taken_e_i,
    input  logic [ADDR_W-1:0]  branch_target_e_i,
    input  logic               pc_src_w_i,
    input  logic [ADDR_W-1:0]  result_w_i,
    fetch_unit_if.master       imem_io,
    output logic [DATA_W-1:0]  instr_d_o,
    output logic [ADDR_W-1:0]  pc_plus8_d_o,
    output logic               valid_d_o
);

    // Queue entries are typed in the package, so the widths must agree with it.
    if (ADDR_W != FETCH_ADDR_W || DATA_W != FETCH_DATA_W) begin : g_width_check
        $error("fetch_unit: ADDR_W/DATA_W must match fetch_pkg widths");
    end

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pcf_q, pcf_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc8_q, pc8_d;
    logic              valid_q, valid_d;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              req;
    logic              granted;
    logic              accept;
    logic              bypass;

    logic [1:0]        q_count;
    fetch_entry_t      q_head;
    fetch_entry_t      q_entry;
    logic              q_push;
    logic              q_pop;
    logic              q_clear;

    // Handshake and queue control.
    always_comb begin
        redirect        = pc_src_w_i || branch_taken_e_i;
        redirect_target = pc_src_w_i ? result_w_i : branch_target_e_i;

        // Reset gating keeps the request low while rst is held.
        req     = !rst && (state_q == StReq) && !stall_f_i && !redirect && (q_count < 2'd2);
        granted = req && imem_io.gnt;

        // A response arriving together with a redirect belongs to the squashed path.
        accept  = (state_q == StResp) && imem_io.rvalid && !redirect;
        bypass  = accept && (q_count == 2'd0) && !stall_d_i && !flush_d_i;
        q_push  = accept && !bypass;
        q_clear = redirect || flush_d_i;
        // Queued words are on the squashed path during a redirect, so never load them.
        q_pop   = !flush_d_i && !stall_d_i && !redirect && (q_count != 2'd0);

        q_entry = '{instr: imem_io.rdata, addr: req_addr_q};
    end

    assign imem_io.req  = req;
    assign imem_io.addr = pcf_q;

    // PC and request FSM.
    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        req_addr_d = req_addr_q;

        if (redirect) begin
            pcf_d = redirect_target;
        end else if (granted) begin
            pcf_d      = pcf_q + PC_INC;
            req_addr_d = pcf_q;
        end

        unique case (state_q)
            StReq: begin
                if (granted) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // Response with a same-cycle redirect is simply discarded; nothing
                // remains outstanding so DROP would wait forever.
                if (imem_io.rvalid) begin
                    state_d = StReq;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (imem_io.rvalid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // Fetch/Decode register.
    always_comb begin
        instr_d = instr_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;

        if (flush_d_i) begin
            valid_d = 1'b0;
        end else if (!stall_d_i) begin
            if (q_pop) begin
                instr_d = q_head.instr;
                pc8_d   = q_head.addr + PC_D_OFS;
                valid_d = 1'b1;
            end else if (bypass) begin
                instr_d = imem_io.rdata;
                pc8_d   = req_addr_q + PC_D_OFS;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StReq;
            pcf_q      <= RESET_PC;
            req_addr_q <= '0;
            instr_q    <= '0;
            pc8_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc8_q      <= pc8_d;
            valid_q    <= valid_d;
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .entry_i (q_entry),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .count_o (q_count),
        .head_o  (q_head)
    );

    assign instr_d_o    = instr_q;
    assign pc_plus8_d_o = pc8_q;
    assign valid_d_o    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit against a one-cycle-latency
// instruction memory that grants immediately. rdata = 0xA5000000 ^ addr.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_f, stall_d, flush_d;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        pc_src_w;
    logic [31:0] result_w;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    logic        valid_d;

    logic        mem_pending;
    logic [31:0] mem_addr;
    logic        hold;

    int n_checks;
    int n_fail;

    fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) imem_if ();

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_f_i         (stall_f),
        .stall_d_i         (stall_d),
        .flush_d_i         (flush_d),
        .branch_taken_e_i  (branch_taken),
        .branch_target_e_i (branch_target),
        .pc_src_w_i        (pc_src_w),
        .result_w_i        (result_w),
        .imem_io           (imem_if),
        .instr_d_o         (instr_d),
        .pc_plus8_d_o      (pc8_d),
        .valid_d_o         (valid_d)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // Memory model: immediate grant, response one cycle later unless held.
    assign imem_if.gnt    = imem_if.req;
    assign imem_if.rvalid = mem_pending && !hold;
    assign imem_if.rdata  = mem_word(mem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pending <= 1'b0;
            mem_addr    <= '0;
        end else begin
            if (imem_if.rvalid) mem_pending <= 1'b0;
            if (imem_if.req && imem_if.gnt) begin
                mem_pending <= 1'b1;
                mem_addr    <= imem_if.addr;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_f = 0; stall_d = 0; flush_d = 0;
        branch_taken = 0; branch_target = '0;
        pc_src_w = 0; result_w = '0;
        hold = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        n_checks++; if (imem_if.req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", imem_if.req); end
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", valid_d); end
        n_checks++; if (instr_d !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr_d); end
        n_checks++; if (pc8_d !== 32'h0) begin n_fail++; $display("FAIL reset_pc8: got %h want 0", pc8_d); end
        n_checks++; if (imem_if.addr !== 32'h0) begin n_fail++; $display("FAIL reset_pcf: got %h want 0", imem_if.addr); end
        rst = 0;
        #1;
        n_checks++; if (imem_if.req !== 1'b1) begin n_fail++; $display("FAIL reset_release_req: got %0h want 1", imem_if.req); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== a) begin n_fail++; $display("FAIL stream_req%0d: got req=%0h addr=%h want req=1 addr=%h", k, imem_if.req, imem_if.addr, a); end
            tick();
            n_checks++; if (imem_if.req !== 1'b0 || valid_d !== 1'b0) begin n_fail++; $display("FAIL stream_resp%0d: got req=%0h valid=%0h want 0 0", k, imem_if.req, valid_d); end
            tick();
            n_checks++; if (valid_d !== 1'b1 || pc8_d !== a + 32'd8 || instr_d !== mem_word(a)) begin n_fail++; $display("FAIL stream_dec%0d: got v=%0h pc8=%h instr=%h want v=1 pc8=%h instr=%h", k, valid_d, pc8_d, instr_d, a + 32'd8, mem_word(a)); end
        end
    endtask

    task automatic test_stall_d();
        do_reset();
        stall_d = 1;
        tick(); tick(); tick(); tick();
        n_checks++; if (imem_if.req !== 1'b0 || valid_d !== 1'b0) begin n_fail++; $display("FAIL stalld_full_c4: got req=%0h valid=%0h want 0 0", imem_if.req, valid_d); end
        tick();
        n_checks++; if (imem_if.req !== 1'b0 || instr_d !== 32'h0) begin n_fail++; $display("FAIL stalld_full_c5: got req=%0h instr=%h want 0 0", imem_if.req, instr_d); end
        tick();
        stall_d = 0;
        #1;
        n_checks++; if (imem_if.req !== 1'b0) begin n_fail++; $display("FAIL stalld_release_req: got %0h want 0", imem_if.req); end
        tick();
        n_checks++; if (valid_d !== 1'b1 || instr_d !== mem_word(32'h0) || pc8_d !== 32'h8) begin n_fail++; $display("FAIL stalld_first: got v=%0h instr=%h pc8=%h want 1 %h 8", valid_d, instr_d, pc8_d, mem_word(32'h0)); end
        n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h8) begin n_fail++; $display("FAIL stalld_next_req: got req=%0h addr=%h want 1 8", imem_if.req, imem_if.addr); end
        tick();
        n_checks++; if (valid_d !== 1'b1 || instr_d !== mem_word(32'h4) || pc8_d !== 32'hC) begin n_fail++; $display("FAIL stalld_second: got v=%0h instr=%h pc8=%h want 1 %h c", valid_d, instr_d, pc8_d, mem_word(32'h4)); end
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        hold = 1;
        branch_taken = 1; branch_target = 32'h100;
        #1;
        n_checks++; if (imem_if.req !== 1'b0) begin n_fail++; $display("FAIL branch_req_during: got %0h want 0", imem_if.req); end
        tick();
        branch_taken = 0; hold = 0;
        #1;
        n_checks++; if (imem_if.req !== 1'b0 || imem_if.addr !== 32'h100) begin n_fail++; $display("FAIL branch_drop: got req=%0h addr=%h want 0 100", imem_if.req, imem_if.addr); end
        tick();
        n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h100 || valid_d !== 1'b0) begin n_fail++; $display("FAIL branch_target_req: got req=%0h addr=%h v=%0h want 1 100 0", imem_if.req, imem_if.addr, valid_d); end
        tick();
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL branch_no_stale: got %0h want 0", valid_d); end
        tick();
        n_checks++; if (valid_d !== 1'b1 || pc8_d !== 32'h108 || instr_d !== mem_word(32'h100)) begin n_fail++; $display("FAIL branch_dec: got v=%0h pc8=%h instr=%h want 1 108 %h", valid_d, pc8_d, instr_d, mem_word(32'h100)); end
    endtask

    task automatic test_priority();
        do_reset();
        pc_src_w = 1; result_w = 32'h200;
        branch_taken = 1; branch_target = 32'h300;
        #1;
        n_checks++; if (imem_if.req !== 1'b0) begin n_fail++; $display("FAIL prio_req_during: got %0h want 0", imem_if.req); end
        tick();
        pc_src_w = 0; branch_taken = 0;
        #1;
        n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h200) begin n_fail++; $display("FAIL prio_addr: got req=%0h addr=%h want 1 200", imem_if.req, imem_if.addr); end
    endtask

    task automatic test_flush();
        do_reset();
        tick(); tick();
        n_checks++; if (valid_d !== 1'b1 || pc8_d !== 32'h8) begin n_fail++; $display("FAIL flush_pre: got v=%0h pc8=%h want 1 8", valid_d, pc8_d); end
        stall_d = 1;
        tick(); tick(); tick(); tick();
        n_checks++; if (imem_if.req !== 1'b0 || valid_d !== 1'b1 || pc8_d !== 32'h8) begin n_fail++; $display("FAIL flush_full: got req=%0h v=%0h pc8=%h want 0 1 8", imem_if.req, valid_d, pc8_d); end
        flush_d = 1;
        tick();
        flush_d = 0; stall_d = 0; stall_f = 1;
        #1;
        n_checks++; if (valid_d !== 1'b0 || imem_if.req !== 1'b0 || imem_if.addr !== 32'hC) begin n_fail++; $display("FAIL flush_after: got v=%0h req=%0h addr=%h want 0 0 c", valid_d, imem_if.req, imem_if.addr); end
        tick();
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL flush_queue_empty: got %0h want 0", valid_d); end
        stall_f = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 0;
        #1;
        n_checks++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got req=%0h addr=%h want 1 fffffffc", imem_if.req, imem_if.addr); end
        tick();
        n_checks++; if (imem_if.req !== 1'b0 || imem_if.addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pcf: got req=%0h addr=%h want 0 0", imem_if.req, imem_if.addr); end
        tick();
        n_checks++; if (valid_d !== 1'b1 || pc8_d !== 32'h4 || instr_d !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_dec: got v=%0h pc8=%h instr=%h want 1 4 %h", valid_d, pc8_d, instr_d, mem_word(32'hFFFF_FFFC)); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1;
        test_reset();
        test_stream();
        test_stall_d();
        test_branch();
        test_priority();
        test_flush();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
